branch_cmp_unit: RTL and testbench
==================================

Name: branch_cmp_unit

Overview:
Parametrised successor to the ID-stage equality comparator. It evaluates the full MIPS branch-condition set (beq/bne/blez/bgtz/bltz/bgez plus always/never) on two operands of configurable width. The result is registered in a one-stage pipeline register with stall and flush control, and the unit sits between the ID operand-forwarding muxes and the NPC/branch-resolution logic. Optional saturating statistics counters track resolved and taken branches.

Parameters:
WIDTH, 32, operand width in bits (>= 2)
STAT_W, 32, width of each statistics counter (only used when BRANCH_STAT_EN is defined)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands/op on this cycle form a branch to resolve
stall  input  1  hold the output register (pipeline freeze)
flush  input  1  kill the output register contents
A  input  WIDTH  operand rs (forwarded)
B  input  WIDTH  operand rt (forwarded); ignored by single-operand ops
Op  input  3  condition select, encoding below
out_valid  output  1  registered result is a valid branch resolution
Taken  output  1  registered branch decision
Eq  output  1  registered A == B
Lt  output  1  registered signed A < 0 (sign bit of A)

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Op encoding: 000 beq (A==B); 001 bne (A!=B); 010 blez (A[WIDTH-1] | A==0); 011 bgtz (!A[WIDTH-1] & A!=0); 100 bltz (A[WIDTH-1]); 101 bgez (!A[WIDTH-1]); 110 always (1); 111 never (0).
- Compare arithmetic: equality is bitwise over all WIDTH bits. Sign tests treat A as two's complement. No subtraction, so there is no overflow case. B is unused for Op 010-111.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Register update priority on each rising edge (highest first):
  1. reset: out_valid=0, Taken=0, Eq=0, Lt=0.
  2. flush: out_valid=0, Taken=0. Eq and Lt are cleared to 0.
  3. stall: all outputs hold their previous values; inputs are ignored.
  4. otherwise: out_valid<=in_valid. If in_valid, Taken/Eq/Lt <= computed values. If !in_valid, Taken/Eq/Lt <= 0.
- Flush and stall asserted together: flush wins, the register is cleared, and nothing is captured.
- Taken is never 1 while out_valid is 0. This is a required invariant.
- Reset mid-stall: reset clears the register regardless of stall or flush.
- Back-to-back valid branches with no stall: a new result every cycle, with no bubble.
- Stall is a 2-state machine, IDLE/HOLD, implicit in the register enable:
  - A held result is re-presented unchanged for the entire stall duration.
  - On the first edge with stall=0, the current inputs are captured.

Optional Feature:
Macro BRANCH_STAT_EN.
- Defined: adds ports stat_clr (input 1), br_cnt (output STAT_W) and taken_cnt (output STAT_W).
  - On each edge that captures with in_valid=1 (no reset, flush or stall), br_cnt increments by 1, and taken_cnt increments by 1 if the computed Taken=1.
  - Both counters saturate at all-ones and do not wrap.
  - reset or stat_clr zeroes both counters. stat_clr has priority over a simultaneous increment.
  - Flushed or stalled cycles are not counted.
- Undefined: the ports and counters do not exist, and the core behaviour is identical.

Test Plan:
1. Reset held 2 cycles with in_valid=1, Op=110 -> out_valid=0, Taken=0 throughout; one cycle after release, out_valid=1, Taken=1.
2. Sweep all 8 Ops with A=0x00000000/B=0; A=0xFFFFFFFF; A=0x00000001/B=0x00000001; A=0x80000000 -> compare Taken against the condition table. Examples: A=0, Op=010 -> 1; A=0, Op=011 -> 0; A=0x80000000, Op=100 -> 1; A=B=1, Op=001 -> 0.
3. beq A=5,B=5 captured, then stall=1 for 3 cycles while inputs change to A=5,B=6 -> Taken=1, Eq=1 held for all 3 cycles; after stall drops, Taken=0 the next cycle.
4. stall=1 and flush=1 on the same edge with a valid taken branch in the register -> out_valid=0, Taken=0 after that edge; a following in_valid=0 cycle keeps both at 0.
5. WIDTH=8 instance: A=0x80, Op=011 -> Taken=0; A=0x7F, Op=011 -> Taken=1; A=0x00, B=0x00, Op=000 -> Eq=1.
6. BRANCH_STAT_EN, STAT_W=2: 5 valid always-branches -> br_cnt=3 (saturated), taken_cnt=3. One flushed branch does not change either count. stat_clr asserted together with a valid branch -> both counters read 0.

Source files
------------

// File: rtl/branch_cmp_unit.sv
// ----------------------------------------------------------------------------
// branch_cmp_unit
//
// Purpose:
//   ID-stage branch condition evaluator. It takes the forwarded rs/rt operands
//   and a 3-bit condition select, evaluates the MIPS branch-condition set, and
//   registers the decision in a single pipeline register. The register supports
//   stall (hold) and flush (kill) control. Its outputs feed the NPC /
//   branch-resolution logic.
//
// Optional feature:
//   Define BRANCH_STAT_EN to add saturating counters for resolved branches and
//   taken branches, plus a synchronous clear input.
//
// Parameters:
//   WIDTH   operand width in bits (>= 2)
//   STAT_W  width of each statistics counter (BRANCH_STAT_EN only)
//
// Ports:
//   clk        in   system clock; all state changes on its rising edge
//   reset      in   synchronous, active-high reset
//   in_valid   in   operands and Op on this cycle form a branch to resolve
//   stall      in   hold the output register
//   flush      in   clear the output register (wins over stall)
//   A          in   operand rs, WIDTH bits
//   B          in   operand rt, WIDTH bits (used by beq/bne only)
//   Op         in   condition select:
//                     000 beq   001 bne   010 blez  011 bgtz
//                     100 bltz  101 bgez  110 always 111 never
//   out_valid  out  registered result is a valid branch resolution
//   Taken      out  registered branch decision
//   Eq         out  registered A == B
//   Lt         out  registered sign bit of A (signed A < 0)
//   stat_clr   in   zero both statistics counters (BRANCH_STAT_EN)
//   br_cnt     out  count of resolved branches, saturating (BRANCH_STAT_EN)
//   taken_cnt  out  count of taken branches, saturating (BRANCH_STAT_EN)
// ----------------------------------------------------------------------------
module branch_cmp_unit #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Op,
`ifdef BRANCH_STAT_EN
    input  logic              stat_clr,
    output logic [STAT_W-1:0] br_cnt,
    output logic [STAT_W-1:0] taken_cnt,
`endif
    output logic             out_valid,
    output logic             Taken,
    output logic             Eq,
    output logic             Lt
);

    // Condition select encodings
    localparam logic [2:0] OP_BEQ    = 3'b000;
    localparam logic [2:0] OP_BNE    = 3'b001;
    localparam logic [2:0] OP_BLEZ   = 3'b010;
    localparam logic [2:0] OP_BGTZ   = 3'b011;
    localparam logic [2:0] OP_BLTZ   = 3'b100;
    localparam logic [2:0] OP_BGEZ   = 3'b101;
    localparam logic [2:0] OP_ALWAYS = 3'b110;
    localparam logic [2:0] OP_NEVER  = 3'b111;

    // ------------------------------------------------------------------------
    // Combinational compare. There is no subtractor: every condition is built
    // from equality, the zero test and the sign bit, so overflow cannot occur.
    // ------------------------------------------------------------------------
    logic w_eq;
    logic w_zero;
    logic w_neg;
    logic w_taken;

    assign w_eq   = (A == B);
    assign w_zero = (A == '0);
    assign w_neg  = A[WIDTH-1];

    always_comb begin
        w_taken = 1'b0;
        case (Op)
            OP_BEQ:    w_taken = w_eq;
            OP_BNE:    w_taken = !w_eq;
            OP_BLEZ:   w_taken = w_neg | w_zero;
            OP_BGTZ:   w_taken = !w_neg & !w_zero;
            OP_BLTZ:   w_taken = w_neg;
            OP_BGEZ:   w_taken = !w_neg;
            OP_ALWAYS: w_taken = 1'b1;
            OP_NEVER:  w_taken = 1'b0;
            default:   w_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Pipeline register control.
    // The IDLE/HOLD stall behaviour is implicit in w_capture: while stall is
    // high (and there is no reset or flush) the register is not enabled, so it
    // re-presents the held result. The first edge with stall low captures the
    // current inputs again.
    // ------------------------------------------------------------------------
    logic w_clear;
    logic w_capture;
    logic w_resolve;

    assign w_clear   = reset | flush;
    assign w_capture = !w_clear & !stall;
    assign w_resolve = w_capture & in_valid;

    logic r_valid;
    logic r_taken;
    logic r_eq;
    logic r_lt;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_valid <= 1'b0;
            r_taken <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
        end else if (w_capture) begin
            // Gating with in_valid keeps Taken low whenever out_valid is low
            r_valid <= in_valid;
            r_taken <= in_valid & w_taken;
            r_eq    <= in_valid & w_eq;
            r_lt    <= in_valid & w_neg;
        end
    end

    assign out_valid = r_valid;
    assign Taken     = r_taken;
    assign Eq        = r_eq;
    assign Lt        = r_lt;

`ifdef BRANCH_STAT_EN
    // ------------------------------------------------------------------------
    // Saturating statistics. Only edges that actually capture a valid branch
    // are counted, so flushed and stalled cycles never contribute.
    // ------------------------------------------------------------------------
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    logic [STAT_W-1:0] r_br_cnt;
    logic [STAT_W-1:0] r_taken_cnt;
    logic              w_br_sat;
    logic              w_taken_sat;

    assign w_br_sat    = &r_br_cnt;
    assign w_taken_sat = &r_taken_cnt;

    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            r_br_cnt    <= '0;
            r_taken_cnt <= '0;
        end else if (w_resolve) begin
            if (!w_br_sat) begin
                r_br_cnt <= r_br_cnt + STAT_ONE;
            end
            if (w_taken && !w_taken_sat) begin
                r_taken_cnt <= r_taken_cnt + STAT_ONE;
            end
        end
    end

    assign br_cnt    = r_br_cnt;
    assign taken_cnt = r_taken_cnt;
`else
    // w_resolve only drives the statistics counters; tie it off here.
    logic w_unused;
    assign w_unused = w_resolve;
`endif

endmodule

// File: tb/tb_branch_cmp_unit.sv
module tb_branch_cmp_unit;

    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, stall, flush;
    logic [31:0] a, b;
    logic [7:0]  a8, b8;
    logic [2:0]  op;
    logic        ov, tk, eq, lt;
    logic        ov8, tk8, eq8, lt8;
`ifdef BRANCH_STAT_EN
    logic          stat_clr;
    logic [SW-1:0] br_cnt, taken_cnt, br8, taken8;
`endif

    branch_cmp_unit #(.WIDTH(32), .STAT_W(SW)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .A(a), .B(b), .Op(op),
`ifdef BRANCH_STAT_EN
        .stat_clr(stat_clr), .br_cnt(br_cnt), .taken_cnt(taken_cnt),
`endif
        .out_valid(ov), .Taken(tk), .Eq(eq), .Lt(lt)
    );

    branch_cmp_unit #(.WIDTH(8), .STAT_W(SW)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .A(a8), .B(b8), .Op(op),
`ifdef BRANCH_STAT_EN
        .stat_clr(stat_clr), .br_cnt(br8), .taken_cnt(taken8),
`endif
        .out_valid(ov8), .Taken(tk8), .Eq(eq8), .Lt(lt8)
    );

    typedef struct packed {
        logic          v;
        logic          t;
        logic          e;
        logic          l;
        logic [SW-1:0] bc;
        logic [SW-1:0] tc;
    } res_t;

    res_t q32[$];
    res_t q8[$];
    res_t m32, m8;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference condition: left-justify A so a plain signed compare against 0
    // works for any width.
    function automatic logic ref_taken(input logic [31:0] av, input logic [31:0] bv,
                                       input logic [2:0] o, input int w);
        logic signed [31:0] s;
        s = av << (32 - w);
        case (o)
            3'd0: return av == bv;
            3'd1: return av != bv;
            3'd2: return s <= 0;
            3'd3: return s > 0;
            3'd4: return s < 0;
            3'd5: return s >= 0;
            3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic res_t ref_next(input res_t cur, input logic [31:0] av,
                                      input logic [31:0] bv, input int w, input logic clr);
        res_t r;
        logic tkn;
        logic signed [31:0] s;
        r   = cur;
        s   = av << (32 - w);
        tkn = ref_taken(av, bv, op, w);
        if (reset || flush) begin
            r.v = 0; r.t = 0; r.e = 0; r.l = 0;
        end else if (!stall) begin
            r.v = in_valid;
            r.t = in_valid && tkn;
            r.e = in_valid && (av == bv);
            r.l = in_valid && (s < 0);
        end
        if (reset || clr) begin
            r.bc = '0; r.tc = '0;
        end else if (!flush && !stall && in_valid) begin
            if (r.bc != {SW{1'b1}}) r.bc = r.bc + 1'b1;
            if (tkn && r.tc != {SW{1'b1}}) r.tc = r.tc + 1'b1;
        end
        return r;
    endfunction

    // Push the expected post-edge state for the current inputs, clock once,
    // then pop and compare.
    task automatic step(input string tag);
        res_t e32, e8;
        logic clr;
`ifdef BRANCH_STAT_EN
        clr = stat_clr;
`else
        clr = 1'b0;
`endif
        m32 = ref_next(m32, a, b, 32, clr);
        m8  = ref_next(m8, {24'd0, a8}, {24'd0, b8}, 8, clr);
        q32.push_back(m32);
        q8.push_back(m8);
        @(posedge clk);
        #1;
        e32 = q32.pop_front();
        e8  = q8.pop_front();
        check_val({tag, ".v"},  ov,  e32.v);
        check_val({tag, ".t"},  tk,  e32.t);
        check_val({tag, ".eq"}, eq,  e32.e);
        check_val({tag, ".lt"}, lt,  e32.l);
        check_val({tag, ".inv"}, tk & ~ov, 0);
        check_val({tag, ".v8"},  ov8, e8.v);
        check_val({tag, ".t8"},  tk8, e8.t);
        check_val({tag, ".eq8"}, eq8, e8.e);
        check_val({tag, ".lt8"}, lt8, e8.l);
`ifdef BRANCH_STAT_EN
        check_val({tag, ".bc"},  br_cnt,    e32.bc);
        check_val({tag, ".tc"},  taken_cnt, e32.tc);
        check_val({tag, ".bc8"}, br8,       e8.bc);
        check_val({tag, ".tc8"}, taken8,    e8.tc);
`endif
    endtask

    logic [31:0] sweep_a [4];
    logic [31:0] sweep_b [4];

    initial begin
        m32 = '0;
        m8  = '0;
        reset = 1; in_valid = 1; stall = 0; flush = 0;
        op = 3'b110; a = 0; b = 0; a8 = 0; b8 = 0;
`ifdef BRANCH_STAT_EN
        stat_clr = 0;
`endif
        // Reset held with a valid always-branch presented
        step("rst0");
        step("rst1");
        reset = 0;
        step("rel");
        check_val("rel.taken_direct", tk, 1);

        // Condition sweep
        sweep_a[0] = 32'h0000_0000; sweep_b[0] = 32'h0;
        sweep_a[1] = 32'hFFFF_FFFF; sweep_b[1] = 32'h0;
        sweep_a[2] = 32'h0000_0001; sweep_b[2] = 32'h1;
        sweep_a[3] = 32'h8000_0000; sweep_b[3] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            for (int o = 0; o < 8; o++) begin
                a = sweep_a[i]; b = sweep_b[i]; a8 = a[7:0]; b8 = b[7:0];
                op = o[2:0];
                step("sweep");
            end
        end
        // Spot values straight from the condition table
        a = 0; op = 3'b010; step("blez0");  check_val("blez0.direct", tk, 1);
        op = 3'b011; step("bgtz0");         check_val("bgtz0.direct", tk, 0);
        a = 32'h8000_0000; op = 3'b100; step("bltz_min"); check_val("bltz_min.direct", tk, 1);
        a = 1; b = 1; op = 3'b001; step("bne_eq");        check_val("bne_eq.direct", tk, 0);

        // Stall holds a captured beq result while inputs change
        a = 5; b = 5; op = 3'b000; a8 = 5; b8 = 5;
        step("beq_cap");
        stall = 1; b = 6; b8 = 6;
        for (int i = 0; i < 3; i++) begin
            step("stall_hold");
            check_val("stall_hold.direct", {tk, eq}, 2'b11);
        end
        stall = 0;
        step("stall_rel");
        check_val("stall_rel.direct", tk, 0);

        // Flush wins over stall
        op = 3'b110;
        step("pre_flush");
        stall = 1; flush = 1;
        step("flush_stall");
        stall = 0; flush = 0; in_valid = 0;
        step("post_flush");
        in_valid = 1;

        // Narrow-width sign and zero handling
        op = 3'b011; a8 = 8'h80; step("w8_bgtz_neg"); check_val("w8_bgtz_neg.direct", tk8, 0);
        a8 = 8'h7F;              step("w8_bgtz_pos"); check_val("w8_bgtz_pos.direct", tk8, 1);
        op = 3'b000; a8 = 0; b8 = 0; step("w8_beq0"); check_val("w8_beq0.direct", eq8, 1);

`ifdef BRANCH_STAT_EN
        // Counter saturation, flush immunity, clear priority
        stat_clr = 1; step("sclr0"); stat_clr = 0;
        op = 3'b110;
        for (int i = 0; i < 5; i++) step("sat");
        check_val("sat.bc_direct", br_cnt, 3);
        check_val("sat.tc_direct", taken_cnt, 3);
        flush = 1; step("sflush"); flush = 0;
        stat_clr = 1; step("sclr_inc"); stat_clr = 0;
        check_val("sclr_inc.bc_direct", br_cnt, 0);
        step("after_clr");
`endif

        // Randomised mix of ops, operands and control
        for (int i = 0; i < 200; i++) begin
            a        = $urandom();
            b        = ($urandom_range(0, 3) == 0) ? a : $urandom();
            a8       = a[7:0];
            b8       = ($urandom_range(0, 3) == 0) ? a8 : b[7:0];
            op       = 3'($urandom_range(0, 7));
            in_valid = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            reset    = ($urandom_range(0, 29) == 0);
`ifdef BRANCH_STAT_EN
            stat_clr = ($urandom_range(0, 19) == 0);
`endif
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
